// File: rtl/tube_scan_driver.sv
// Eight-tube multiplexed seven-segment scanner; the input word is snapshotted once per frame.
// Optional leading-zero blanking of the hour pair (tubes 7/6) is enabled with TUBE_LZ_BLANK_EN.
module tube_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] time_data,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [31:0]      snap_reg, snap_next;
    logic             tick;
    logic [3:0]       nib;
    logic [7:0]       seg;
    logic             blank;
    logic [7:0]       tube_sel_next, digit1_next, digit2_next;

    assign tick = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            idx_reg  <= 3'd0;
            snap_reg <= 32'h0;
            tube_sel <= 8'h00;
            digit1   <= 8'h00;
            digit2   <= 8'h00;
        end else begin
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            snap_reg <= snap_next;
            tube_sel <= tube_sel_next;
            digit1   <= digit1_next;
            digit2   <= digit2_next;
        end
    end

    // The snapshot reloads only on the tick that wraps idx 7->0, so a frame never mixes two words.
    always_comb begin
        cnt_next  = tick ? '0 : cnt_reg + CNT_W'(1);
        idx_next  = tick ? idx_reg + 3'd1 : idx_reg;
        snap_next = (tick && (idx_reg == 3'd7)) ? time_data : snap_reg;
    end

    assign nib = snap_reg[{idx_reg, 2'b00} +: 4];

    always_comb begin
        case (nib)
            4'h0: seg = 8'hFC;
            4'h1: seg = 8'h60;
            4'h2: seg = 8'hDA;
            4'h3: seg = 8'hF2;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'hB6;
            4'h6: seg = 8'hBE;
            4'h7: seg = 8'hE0;
            4'h8: seg = 8'hFE;
            4'h9: seg = 8'hF6;
            4'hA: seg = 8'hEE;
            4'hB: seg = 8'h3E;
            4'hC: seg = 8'h9C;
            4'hD: seg = 8'h7A;
            4'hE: seg = 8'h9E;
            default: seg = 8'h02;
        endcase
    end

`ifdef TUBE_LZ_BLANK_EN
    always_comb begin
        blank = ((idx_reg == 3'd7) && (snap_reg[31:28] == 4'h0)) ||
                ((idx_reg == 3'd6) && (snap_reg[31:24] == 8'h00));
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sel
            assign tube_sel_next[gi] = en && (idx_reg == 3'(gi));
        end
    endgenerate

    // Tubes 7..4 sit on digit1, tubes 3..0 on digit2; the inactive group stays dark.
    always_comb begin
        digit1_next = (en && idx_reg[2] && !blank) ? seg : 8'h00;
        digit2_next = (en && !idx_reg[2]) ? seg : 8'h00;
    end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Directed bench for tube_scan_driver with SCAN_DIV=4 (one frame = 32 cycles).
// Expectations for tubes 6/7 with a zero top byte follow TUBE_LZ_BLANK_EN.
module tb_tube_scan_driver;

    localparam int SCAN_DIV = 4;
`ifdef TUBE_LZ_BLANK_EN
    localparam logic [7:0] ZHI = 8'h00;
`else
    localparam logic [7:0] ZHI = 8'hFC;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [31:0] time_data = 32'h0;
    logic [7:0]  digit1, digit2, tube_sel;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_seg [0:7];

    always #5 clk = ~clk;

    tube_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .time_data (time_data),
        .digit1    (digit1),
        .digit2    (digit2),
        .tube_sel  (tube_sel)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_sel,
                           input logic [7:0] e_d1, input logic [7:0] e_d2);
        chk({tag, " tube_sel"}, tube_sel, e_sel);
        chk({tag, " digit1"}, digit1, e_d1);
        chk({tag, " digit2"}, digit2, e_d2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) tick();
    endtask

    // Expected outputs for tube k showing segment pattern s.
    task automatic chk_tube(input string tag, input int k, input logic [7:0] s);
        logic [7:0] sel;
        sel = 8'h01 << k;
        if (k >= 4) chk_out(tag, sel, s, 8'h00);
        else        chk_out(tag, sel, 8'h00, s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and first scan
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset state", 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        cyc = 0;
        tick();
        chk_out("first edge", 8'h01, 8'h00, 8'hFC);
        go_to(4);
        chk("dwell end t0 tube_sel", tube_sel, 8'h01);
        go_to(5);
        chk_out("advance t1", 8'h02, 8'h00, 8'hFC);
        go_to(21);
        chk_out("pre-reset t5", 8'h20, 8'hFC, 8'h00);

        // Asynchronous reset mid-scan at idx=5
        rst = 1'b1;
        #1;
        chk_out("async reset", 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset held", 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        cyc = 0;
        time_data = 32'h00F0_3F59;
        tick();
        chk_out("restart", 8'h01, 8'h00, 8'hFC);
        go_to(29);
        chk_out("pre-capture t7", 8'h80, ZHI, 8'h00);

        // Decode frame for 00F0_3F59 (captured at edge 32)
        exp_seg = '{8'hF6, 8'hB6, 8'h02, 8'hF2, 8'hFC, 8'h02, ZHI, ZHI};
        for (int k = 0; k < 8; k++) begin
            go_to(33 + 4 * k);
            chk_tube($sformatf("decode t%0d", k), k, exp_seg[k]);
        end
        time_data = 32'h0000_0000;

        // Anti-tearing: change input at idx=3 of the zero frame
        go_to(76);
        time_data = 32'h7777_7777;
        exp_seg = '{8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, ZHI, ZHI};
        for (int k = 4; k < 8; k++) begin
            go_to(65 + 4 * k);
            chk_tube($sformatf("no tear t%0d", k), k, exp_seg[k]);
        end
        for (int k = 0; k < 8; k++) begin
            go_to(97 + 4 * k);
            chk_tube($sformatf("new frame t%0d", k), k, 8'hE0);
        end

        // Enable gating: drop at idx=2, raise 10 cycles later
        go_to(137);
        chk_out("before en drop", 8'h04, 8'h00, 8'hE0);
        en = 1'b0;
        tick();
        chk_out("en dropped", 8'h00, 8'h00, 8'h00);
        go_to(147);
        chk_out("en low held", 8'h00, 8'h00, 8'h00);
        en = 1'b1;
        tick();
        chk_out("en resumed t4", 8'h10, 8'hE0, 8'h00);
        go_to(153);
        chk_out("en continue t6", 8'h40, 8'hE0, 8'h00);

        // Hex letters, captured at edge 160
        time_data = 32'hEDCB_A987;
        exp_seg = '{8'hE0, 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E};
        for (int k = 0; k < 8; k++) begin
            go_to(161 + 4 * k);
            chk_tube($sformatf("hex t%0d", k), k, exp_seg[k]);
            go_to(164 + 4 * k);
            chk($sformatf("hex dwell end t%0d tube_sel", k), tube_sel, 8'h01 << k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
